// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, start/busy/done).
// Define BCD_DOUBLE_STEP_EN to run two shift/adjust iterations per clock.
module bcd_to_binary #(
    parameter int NIBBLES               = 6,
    parameter int BCD_WIDTH             = NIBBLES * 4,
    parameter int BIN_WIDTH             = 20,
    parameter int STEP_COUNTER_BITWIDTH = $clog2(BIN_WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BCD_WIDTH-1:0] bcdIn,
    output logic [BIN_WIDTH-1:0] binaryOut,
    output logic                 busy,
    output logic                 done,
    output logic                 invalid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam int REG_W = BCD_WIDTH + BIN_WIDTH;

`ifdef BCD_DOUBLE_STEP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [STEP_COUNTER_BITWIDTH-1:0] LAST =
        STEP_COUNTER_BITWIDTH'(BIN_WIDTH - STEP);
    localparam logic [STEP_COUNTER_BITWIDTH-1:0] INC =
        STEP_COUNTER_BITWIDTH'(STEP);

    logic [0:0]                       state;
    logic [REG_W-1:0]                 shreg;
    logic [REG_W-1:0]                 next_reg;
    logic [STEP_COUNTER_BITWIDTH-1:0] cnt;
    logic                             bcd_ok;

    // Shift right, then pull 3 out of every BCD nibble that reached 8 or more.
    function automatic logic [REG_W-1:0] dabble(input logic [REG_W-1:0] v);
        logic [REG_W-1:0] s;
        logic [3:0]       nib;
        s = v >> 1;
        for (int i = 0; i < NIBBLES; i++) begin
            nib = s[BIN_WIDTH + 4*i +: 4];
            if (nib >= 4'd8)
                s[BIN_WIDTH + 4*i +: 4] = nib - 4'd3;
        end
        return s;
    endfunction

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < NIBBLES; i++)
            if (bcdIn[4*i +: 4] > 4'd9)
                bcd_ok = 1'b0;
    end

    always_comb begin
`ifdef BCD_DOUBLE_STEP_EN
        next_reg = dabble(dabble(shreg));
`else
        next_reg = dabble(shreg);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            binaryOut <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (bcd_ok) begin
                            shreg <= {bcdIn, {BIN_WIDTH{1'b0}}};
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            binaryOut <= '0;
                            invalid   <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= next_reg;
                    cnt   <= cnt + INC;
                    if (cnt == LAST) begin
                        binaryOut <= next_reg[BIN_WIDTH-1:0];
                        invalid   <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: random and directed conversions
// checked against a decimal arithmetic reference model.
module tb_bcd_to_binary;

`ifdef BCD_DOUBLE_STEP_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 21;
`endif

    typedef struct {
        int          cyc;
        logic [19:0] bin;
        logic        inv;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] bcdIn = '0;
    logic [19:0] binaryOut;
    logic        busy;
    logic        done;
    logic        invalid;

    bcd_to_binary dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bcdIn     (bcdIn),
        .binaryOut (binaryOut),
        .busy      (busy),
        .done      (done),
        .invalid   (invalid)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    exp_t        sb[$];
    int          free_cyc  = 0;
    int          busy_from = 0;
    logic [19:0] held_bin  = '0;
    logic        held_inv  = 1'b0;
    logic        armed     = 1'b0;
    int          n_chk     = 0;
    int          n_fail    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: decimal weighting of each digit; any digit above 9 is invalid.
    function automatic void ref_conv(input logic [23:0] v,
                                     output logic [19:0] bin,
                                     output logic inv);
        int acc = 0;
        int w   = 1;
        inv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int d = int'((v >> (4 * i)) & 24'hF);
            if (d > 9) inv = 1'b1;
            acc += d * w;
            w   *= 10;
        end
        bin = inv ? 20'd0 : acc[19:0];
    endfunction

    task automatic drive(input logic s, input logic [23:0] v, input logic r);
        exp_t e;
        @(posedge clock);
        #1;
        start = s;
        bcdIn = v;
        reset = r;
        if (r) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].cyc > cyc) sb.delete(i);
            free_cyc  = cyc + 1;
            busy_from = cyc + 1;
        end else if (s && cyc >= free_cyc) begin
            ref_conv(v, e.bin, e.inv);
            if (e.inv) begin
                e.cyc     = cyc + 1;
                free_cyc  = cyc + 1;
                busy_from = free_cyc;
            end else begin
                e.cyc     = cyc + LAT;
                free_cyc  = cyc + LAT;
                busy_from = cyc + 1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0);
    endtask

    function automatic logic [23:0] rand_bcd(input logic allow_bad);
        logic [23:0] v = '0;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] d = 4'($urandom_range(0, 9));
            if (allow_bad && $urandom_range(0, 15) == 0)
                d = 4'($urandom_range(10, 15));
            v[4*i +: 4] = d;
        end
        return v;
    endfunction

    always @(negedge clock) begin
        if (armed) begin
            exp_t e;
            if (rst_q) begin
                held_bin = '0;
                held_inv = 1'b0;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    held_bin = e.bin;
                    held_inv = e.inv;
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("missing_done", 32'(done), 32'd1);
                void'(sb.pop_front());
            end
            chk("binaryOut", 32'(binaryOut), 32'(held_bin));
            chk("invalid", 32'(invalid), 32'(held_inv));
            if (!reset)
                chk("busy", 32'(busy),
                    32'(cyc >= busy_from && cyc < free_cyc));
        end
    end

    initial begin
        int c;
        drive(1'b0, 24'h0, 1'b1);
        drive(1'b0, 24'h0, 1'b1);
        drive(1'b0, 24'h0, 1'b0);
        armed = 1'b1;
        idle(2);

        drive(1'b1, 24'h000000, 1'b0);
        idle(LAT + 2);
        drive(1'b1, 24'h123456, 1'b0);
        idle(LAT + 1);
        drive(1'b1, 24'h999999, 1'b0);
        idle(LAT + 1);

        drive(1'b1, 24'h0000A0, 1'b0);
        drive(1'b1, 24'h000042, 1'b0);
        idle(LAT + 1);

        for (int i = 0; i < 3 * LAT + 1; i++)
            drive(1'b1, 24'h000010, 1'b0);
        idle(LAT + 1);

        drive(1'b1, 24'h000010, 1'b0);
        for (int i = 0; i < LAT - 1; i++)
            drive(1'($urandom_range(0, 1)), rand_bcd(1'b1), 1'b0);
        idle(LAT + 1);

        drive(1'b1, 24'h555555, 1'b0);
        idle(9);
        drive(1'b0, 24'h0, 1'b1);
        drive(1'b0, 24'h0, 1'b0);
        drive(1'b1, 24'h000007, 1'b0);
        idle(LAT + 1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                drive(1'b0, 24'h0, 1'b1);
            else
                drive(1'($urandom_range(0, 2) != 0), rand_bcd(1'b1), 1'b0);
        end
        drive(1'b0, 24'h0, 1'b0);

        c = 0;
        while (sb.size() > 0 && c < 4 * LAT) begin
            idle(1);
            c++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
